// File: rtl/angle_reducer.sv
// -----------------------------------------------------------------------------
// angle_reducer
//
// Upstream stage of the trig LUTs. Takes an integer-degree angle, reduces it
// modulo 360 with a restoring shift-and-subtract loop (one step per cycle), and
// returns the quadrant (0..3) and the reference angle (0..90) that the LUTs
// index. One job is in flight at a time; valid/ready handshakes on both sides.
//
// Optional feature macro: SIGNED_ANGLE_EN
//   defined   : angle_in is two's complement. The magnitude is reduced, then a
//               NEG fix-up cycle maps a negative residue r != 0 to 360 - r.
//               Latency K+2 cycles from the accept edge to out_valid.
//   undefined : angle_in is unsigned, no fix-up cycle, latency K+1.
//   (K = ANGLE_W - 8 reduction steps.)
//
// Parameters
//   ANGLE_W  input angle width in degrees (>= 10)
//   REF_W    reference-angle output width (must hold 0..90)
//   TAG_W    opaque tag width, carried alongside the angle
//
// Ports
//   clk        in   1        clock, all logic on posedge
//   reset_n    in   1        synchronous reset, active-low
//   in_valid   in   1        input angle valid
//   in_ready   out  1        block is idle and can accept an angle
//   angle_in   in   ANGLE_W  angle in degrees
//   tag_in     in   TAG_W    tag captured together with angle_in
//   out_valid  out  1        result valid, held until accepted
//   out_ready  in   1        downstream accepts the result
//   quadrant   out  2        0:[0,90) 1:[90,180) 2:[180,270) 3:[270,360)
//   ref_angle  out  REF_W    reference angle 0..90
//   tag_out    out  TAG_W    tag of the current result
//   busy       out  1        high while reducing / fixing up / mapping
// -----------------------------------------------------------------------------
module angle_reducer #(
  parameter int ANGLE_W = 16,
  parameter int REF_W   = 7,
  parameter int TAG_W   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANGLE_W-1:0] angle_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         quadrant,
  output logic [REF_W-1:0]   ref_angle,
  output logic [TAG_W-1:0]   tag_out,
  output logic               busy
);

  // Number of reduction steps. 360 << K exceeds 2^ANGLE_W, so any input
  // magnitude is below the first subtrahend's doubling and K steps suffice.
  localparam int K  = ANGLE_W - 8;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  // Subtrahend base is one bit wider than the residue so 360 << k never
  // truncates for the largest k.
  localparam logic [ANGLE_W:0] DEG360_WIDE = (ANGLE_W + 1)'(360);

`ifdef SIGNED_ANGLE_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_NEG    = 3'd2,
    ST_MAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_MAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;
`endif

  state_t             state_r;
  logic [ANGLE_W-1:0] r_r;
  logic [KW-1:0]      k_r;
  logic [TAG_W-1:0]   tag_r;
  logic               out_valid_r;
  logic [1:0]         quadrant_r;
  logic [REF_W-1:0]   ref_angle_r;
  logic [TAG_W-1:0]   tag_out_r;
`ifdef SIGNED_ANGLE_EN
  logic               neg_r;
  logic [ANGLE_W-1:0] fix_r_s;
`endif

  logic [ANGLE_W-1:0] mag_s;
  logic [ANGLE_W:0]   sub_s;
  logic [ANGLE_W-1:0] step_r_s;
  logic [1:0]         map_q_s;
  logic [REF_W-1:0]   map_ref_s;

  // Magnitude of the incoming angle (two's complement negate when signed).
  always_comb begin
    mag_s = angle_in;
`ifdef SIGNED_ANGLE_EN
    if (angle_in[ANGLE_W-1]) begin
      // The most-negative value negates to 2^(ANGLE_W-1), which still fits
      // unsigned in ANGLE_W bits.
      mag_s = ~angle_in + {{(ANGLE_W-1){1'b0}}, 1'b1};
    end else begin
      mag_s = angle_in;
    end
`endif
  end

  // One restoring reduction step: subtract 360 << k when it fits.
  always_comb begin
    sub_s    = DEG360_WIDE << k_r;
    step_r_s = r_r;
    if ({1'b0, r_r} >= sub_s) begin
      step_r_s = ANGLE_W'({1'b0, r_r} - sub_s);
    end else begin
      step_r_s = r_r;
    end
  end

`ifdef SIGNED_ANGLE_EN
  // Reflection of a negative angle's residue into [0,360).
  always_comb begin
    fix_r_s = ANGLE_W'(360) - r_r;
  end
`endif

  // Quadrant / reference-angle mapping of the fully reduced residue (r < 360).
  always_comb begin
    map_q_s   = 2'd0;
    map_ref_s = {REF_W{1'b0}};
    if (r_r < ANGLE_W'(90)) begin
      map_q_s   = 2'd0;
      map_ref_s = REF_W'(r_r);
    end else if (r_r < ANGLE_W'(180)) begin
      map_q_s   = 2'd1;
      map_ref_s = REF_W'(ANGLE_W'(180) - r_r);
    end else if (r_r < ANGLE_W'(270)) begin
      map_q_s   = 2'd2;
      map_ref_s = REF_W'(r_r - ANGLE_W'(180));
    end else begin
      map_q_s   = 2'd3;
      map_ref_s = REF_W'(ANGLE_W'(360) - r_r);
    end
  end

  // Control FSM with datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      r_r         <= {ANGLE_W{1'b0}};
      k_r         <= {KW{1'b0}};
      tag_r       <= {TAG_W{1'b0}};
      out_valid_r <= 1'b0;
      quadrant_r  <= 2'd0;
      ref_angle_r <= {REF_W{1'b0}};
      tag_out_r   <= {TAG_W{1'b0}};
`ifdef SIGNED_ANGLE_EN
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            r_r     <= mag_s;
            tag_r   <= tag_in;
            k_r     <= KW'(K - 1);
`ifdef SIGNED_ANGLE_EN
            neg_r   <= angle_in[ANGLE_W-1];
`endif
            state_r <= ST_REDUCE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REDUCE: begin
          r_r <= step_r_s;
          if (k_r == {KW{1'b0}}) begin
`ifdef SIGNED_ANGLE_EN
            state_r <= ST_NEG;
`else
            state_r <= ST_MAP;
`endif
          end else begin
            k_r     <= k_r - KW'(1);
            state_r <= ST_REDUCE;
          end
        end
`ifdef SIGNED_ANGLE_EN
        ST_NEG: begin
          // A zero residue stays zero: -360 maps to 0, not 360.
          if (neg_r && (r_r != {ANGLE_W{1'b0}})) begin
            r_r <= fix_r_s;
          end else begin
            r_r <= r_r;
          end
          state_r <= ST_MAP;
        end
`endif
        ST_MAP: begin
          quadrant_r  <= map_q_s;
          ref_angle_r <= map_ref_s;
          tag_out_r   <= tag_r;
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          // Outputs hold until downstream takes the result.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
`ifdef SIGNED_ANGLE_EN
  assign busy      = (state_r == ST_REDUCE) || (state_r == ST_NEG) || (state_r == ST_MAP);
`else
  assign busy      = (state_r == ST_REDUCE) || (state_r == ST_MAP);
`endif
  assign out_valid = out_valid_r;
  assign quadrant  = quadrant_r;
  assign ref_angle = ref_angle_r;
  assign tag_out   = tag_out_r;

endmodule

// File: tb/tb_angle_reducer.sv
module tb_angle_reducer;

  localparam int ANGLE_W = 16;
  localparam int REF_W   = 7;
  localparam int TAG_W   = 3;
  localparam int K       = ANGLE_W - 8;
`ifdef SIGNED_ANGLE_EN
  localparam int LAT = K + 2;
`else
  localparam int LAT = K + 1;
`endif
  localparam int PERIOD = LAT + 2;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [ANGLE_W-1:0] angle_in;
  logic [TAG_W-1:0]   tag_in;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         quadrant;
  logic [REF_W-1:0]   ref_angle;
  logic [TAG_W-1:0]   tag_out;
  logic               busy;

  int n_vec = 0;
  int n_bad = 0;

  angle_reducer #(.ANGLE_W(ANGLE_W), .REF_W(REF_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .angle_in(angle_in), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .quadrant(quadrant), .ref_angle(ref_angle),
    .tag_out(tag_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int angle;
    int tag;
    int q;
    int rf;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int t, input int q, input int rf);
    vec_t v;
    v.angle = a; v.tag = t; v.q = q; v.rf = rf;
    return v;
  endfunction

  // Reference: plain modulo arithmetic, then the quadrant rules.
  task automatic model(input int a, output int q, output int rf);
    int r;
    r = ((a % 360) + 360) % 360;
    if (r < 90)       begin q = 0; rf = r;       end
    else if (r < 180) begin q = 1; rf = 180 - r; end
    else if (r < 270) begin q = 2; rf = r - 180; end
    else              begin q = 3; rf = 360 - r; end
  endtask

  // Present one angle, accept it, and wait (bounded) for out_valid.
  task automatic run_job(input logic [ANGLE_W-1:0] a, input logic [TAG_W-1:0] t,
                         output int lat, output bit got);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    angle_in = a; tag_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) got = 1'b1;
    end
    if (!got) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  // Release the result and check the handshake completes on the next edge.
  task automatic finish_job();
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_return", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    bit got;
    int eq, erf;
    int a;
    logic [ANGLE_W-1:0] av;
    logic [TAG_W-1:0]   tv;
    int d;
    int edges [$];
    bit seen;

`ifdef SIGNED_ANGLE_EN
    vecs[0]  = mk(0, 5, 0, 0);       vecs[1]  = mk(-30, 1, 3, 30);
    vecs[2]  = mk(-360, 2, 0, 0);    vecs[3]  = mk(-32768, 3, 3, 8);
    vecs[4]  = mk(90, 4, 1, 90);     vecs[5]  = mk(180, 5, 2, 0);
    vecs[6]  = mk(270, 6, 3, 90);    vecs[7]  = mk(1020, 7, 3, 60);
    vecs[8]  = mk(-90, 0, 3, 90);    vecs[9]  = mk(-1, 1, 3, 1);
    vecs[10] = mk(32767, 2, 0, 7);   vecs[11] = mk(-180, 3, 2, 0);
    vecs[12] = mk(-270, 4, 1, 90);   vecs[13] = mk(360, 5, 0, 0);
    vecs[14] = mk(-359, 6, 0, 1);    vecs[15] = mk(-720, 7, 0, 0);
`else
    vecs[0]  = mk(0, 5, 0, 0);       vecs[1]  = mk(90, 1, 1, 90);
    vecs[2]  = mk(180, 2, 2, 0);     vecs[3]  = mk(270, 3, 3, 90);
    vecs[4]  = mk(1020, 4, 3, 60);   vecs[5]  = mk(65535, 5, 0, 15);
    vecs[6]  = mk(359, 6, 3, 1);     vecs[7]  = mk(360, 7, 0, 0);
    vecs[8]  = mk(89, 0, 0, 89);     vecs[9]  = mk(91, 1, 1, 89);
    vecs[10] = mk(179, 2, 1, 1);     vecs[11] = mk(181, 3, 2, 1);
    vecs[12] = mk(269, 4, 2, 89);    vecs[13] = mk(271, 5, 3, 89);
    vecs[14] = mk(720, 6, 0, 0);     vecs[15] = mk(450, 7, 1, 90);
`endif

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    angle_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_quadrant", 32'(quadrant), 32'd0);
    check("rst_ref_angle", 32'(ref_angle), 32'd0);
    check("rst_tag_out", 32'(tag_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'b0;
      run_job(ANGLE_W'(vecs[i].angle), TAG_W'(vecs[i].tag), lat, got);
      if (got) begin
        check("tbl_latency", 32'(lat), 32'(LAT));
        check("tbl_quadrant", 32'(quadrant), 32'(vecs[i].q));
        check("tbl_ref_angle", 32'(ref_angle), 32'(vecs[i].rf));
        check("tbl_tag_out", 32'(tag_out), 32'(vecs[i].tag));
      end
      finish_job();
    end

    // Backpressure: result held, in_valid pulses ignored.
    out_ready = 1'b0;
    run_job(ANGLE_W'(1020), 3'd6, lat, got);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      angle_in = ANGLE_W'(90); tag_in = 3'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quadrant", 32'(quadrant), 32'd3);
      check("bp_ref_angle", 32'(ref_angle), 32'd60);
      check("bp_tag_out", 32'(tag_out), 32'd6);
    end
    finish_job();
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_spurious_job", 32'(busy), 32'd0);

    // Reset in the middle of a reduction.
    out_ready = 1'b1;
    @(negedge clk);
    angle_in = ANGLE_W'(12345); tag_in = 3'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_quadrant", 32'(quadrant), 32'd0);
    check("mid_rst_ref_angle", 32'(ref_angle), 32'd0);
    check("mid_rst_tag_out", 32'(tag_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_emit", 32'(seen), 32'd0);

    // Back-to-back throughput with in_valid and out_ready held high.
    out_ready = 1'b1;
    @(negedge clk);
    angle_in = ANGLE_W'(123); tag_in = 3'd2; in_valid = 1'b1;
    for (int c = 0; c < 4 * PERIOD + 4; c++) begin
      @(posedge clk); #1;
      if (out_valid) edges.push_back(c);
    end
    in_valid = 1'b0;
    check("tput_count", 32'(edges.size() >= 3), 32'd1);
    if (edges.size() >= 3) begin
      check("tput_gap1", 32'(edges[1] - edges[0]), 32'(K + 3 + LAT - (K + 1)));
      check("tput_gap2", 32'(edges[2] - edges[1]), 32'(K + 3 + LAT - (K + 1)));
    end
    repeat (2 * PERIOD) @(posedge clk);
    #1;
    check("tput_drained", 32'(in_ready), 32'd1);

    // Randomized jobs against the reference model.
    for (int n = 0; n < 200; n++) begin
      av = ANGLE_W'($urandom);
      tv = TAG_W'($urandom);
`ifdef SIGNED_ANGLE_EN
      a = int'($signed(av));
`else
      a = int'(av);
`endif
      model(a, eq, erf);
      out_ready = 1'b0;
      run_job(av, tv, lat, got);
      if (got) begin
        check("rnd_latency", 32'(lat), 32'(LAT));
        check("rnd_quadrant", 32'(quadrant), 32'(eq));
        check("rnd_ref_angle", 32'(ref_angle), 32'(erf));
        check("rnd_tag_out", 32'(tag_out), 32'(tv));
        d = $urandom_range(0, 3);
        for (int w = 0; w < d; w++) begin
          @(posedge clk); #1;
          check("rnd_hold_valid", 32'(out_valid), 32'd1);
        end
      end
      finish_job();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
